regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, number of architectural registers (power of two, 2..64).
REQ-003 SHALL have parameter ADDR_W, default $clog2(NUM_REGS), register address width.
REQ-004 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable.
REQ-005 SHALL have parameter ZERO_REG, default 1; if 1, register 0 is hardwired to zero.
REQ-006 One clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-007 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have rd_en  input  1  read request for both ports.
REQ-009 SHALL have rd_addr0 / rd_addr1  input  ADDR_W each  source register addresses.
REQ-010 SHALL have rd_data0 / rd_data1  output  DATA_W each  registered read data.
REQ-011 SHALL have rd_busy0 / rd_busy1  output  1 each  registered pending-write flag of the addressed register.
REQ-012 SHALL have rd_valid  output  1  read data valid, one cycle after rd_en.
REQ-013 SHALL have wr_en, wr_addr, wr_data  input  1/ADDR_W/DATA_W  write-back port.
REQ-014 SHALL have rsv_en, rsv_addr  input  1/ADDR_W  destination reservation (issue) port.
REQ-015 SHALL have busy_vec  output  NUM_REGS  live scoreboard, bit i = register i pending.

Function
REQ-016 Read latency SHALL be exactly one cycle: rd_data*, rd_busy* and rd_valid update on the clk edge after rd_en is sampled high.
REQ-017 With rd_en low, rd_data*, rd_busy* SHALL hold; rd_valid SHALL be 0.
REQ-018 A write with wr_en high SHALL update the register at the clk edge.
REQ-019 With ZERO_REG=1, writes to address 0 SHALL be dropped; reads of address 0 SHALL return 0, busy 0; reservations of address 0 SHALL be ignored.
REQ-020 With BYPASS=1, a read and a write to the same address in the same cycle SHALL return wr_data; with BYPASS=0 it SHALL return the old value.
REQ-021 Bypass SHALL apply independently per read port, including both ports on the same address.
REQ-022 rsv_en SHALL set busy bit of rsv_addr at the clk edge; wr_en SHALL clear busy bit of wr_addr.
REQ-023 Same-cycle rsv and wr on the same address: busy SHALL end set (new reservation wins); data SHALL still be written.
REQ-024 rd_busy* SHALL reflect busy state after that cycle's wr clear but before that cycle's rsv set (with BYPASS=1); with BYPASS=0 it SHALL reflect pre-edge state.
REQ-025 A write to a non-busy register SHALL be accepted and leave busy at 0 (no error).
REQ-026 Per-register state machine: IDLE -(rsv)-> PENDING -(wr)-> IDLE; PENDING -(rsv and wr)-> PENDING.

Reset
REQ-027 rst_n low SHALL asynchronously clear all registers, busy_vec, rd_data*, rd_busy*, rd_valid to 0.
REQ-028 Reset asserted mid-operation SHALL discard any same-cycle write, reservation or read; first read after release SHALL return 0.
REQ-029 Inputs SHALL be ignored while rst_n is low; operation resumes on the first clk edge with rst_n high.

Structure
REQ-030 Shared package regfile_pkg SHALL hold default DATA_W/NUM_REGS and the per-register state enum (IDLE, PENDING).
REQ-031 Scoreboard SHALL be a sub-module regfile_scoreboard (busy_vec, rsv/wr set/clear, priority rule); storage and read/bypass logic stay in regfile_sb.

Verification
REQ-032 Reset, then rd_en with rd_addr0=5, rd_addr1=9 -> next cycle rd_data0=0, rd_data1=0, rd_valid=1.
REQ-033 Write 0xDEADBEEF to r8, next cycle read r8 on both ports -> both rd_data=0xDEADBEEF.
REQ-034 BYPASS=1: same-cycle write 0x12345678 to r3 and read r3 -> rd_data0=0x12345678; BYPASS=0 -> old value 0.
REQ-035 Write 0xFFFFFFFF to r0 (ZERO_REG=1), then read r0 -> 0; rsv r0 -> busy_vec[0]=0.
REQ-036 rsv r10; read r10 -> rd_busy0=1; same-cycle rsv r10 and wr r10=7 -> busy_vec[10]=1, r10 reads 7.
REQ-037 Write r4=0xA5 then pulse rst_n low between edges -> busy_vec=0, r4 reads 0 after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and the per-register scoreboard state for the register file.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } reg_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracker: reservation sets, write-back clears, reservation wins a tie.
// busy_fwd is busy_vec with this cycle's write-back clears already applied.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [NUM_REGS-1:0] busy_fwd
);

  reg_state_e        state [NUM_REGS];
  logic [NUM_REGS-1:0] rsv_hit;
  logic [NUM_REGS-1:0] wr_hit;

  always_comb begin
    rsv_hit  = '0;
    wr_hit   = '0;
    busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rsv_hit[i]  = rsv_en && (rsv_addr == ADDR_W'(i));
      wr_hit[i]   = wr_en && (wr_addr == ADDR_W'(i));
      busy_vec[i] = (state[i] == PENDING);
    end
  end

  assign busy_fwd = busy_vec & ~wr_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) state[i] <= IDLE;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // A hardwired zero register can never have a write outstanding.
        if (ZERO_REG != 0 && i == 0) begin
          state[i] <= IDLE;
        end else begin
          case (state[i])
            IDLE:    if (rsv_hit[i]) state[i] <= PENDING;
            PENDING: if (wr_hit[i] && !rsv_hit[i]) state[i] <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with optional write forwarding and a pending-write scoreboard.
// Reads return registered data and busy one cycle after rd_en; outputs hold while rd_en is low.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr0,
  input  logic [ADDR_W-1:0]   rd_addr1,
  output logic [DATA_W-1:0]   rd_data0,
  output logic [DATA_W-1:0]   rd_data1,
  output logic                rd_busy0,
  output logic                rd_busy1,
  output logic                rd_valid,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_fwd;
  logic [NUM_REGS-1:0] busy_src;
  logic [DATA_W-1:0]   rdata0, rdata1;
  logic                wr_ok;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (busy_vec),
    .busy_fwd (busy_fwd)
  );

  assign wr_ok    = wr_en && (ZERO_REG == 0 || wr_addr != '0);
  assign busy_src = (BYPASS != 0) ? busy_fwd : busy_vec;

  // Zero-register check comes last so it overrides any forwarded write to r0.
  always_comb begin
    rdata0 = regs[rd_addr0];
    rdata1 = regs[rd_addr1];
    if (BYPASS != 0 && wr_en && wr_addr == rd_addr0) rdata0 = wr_data;
    if (BYPASS != 0 && wr_en && wr_addr == rd_addr1) rdata1 = wr_data;
    if (ZERO_REG != 0 && rd_addr0 == '0) rdata0 = '0;
    if (ZERO_REG != 0 && rd_addr1 == '0) rdata1 = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data0 <= '0;
      rd_data1 <= '0;
      rd_busy0 <= 1'b0;
      rd_busy1 <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data0 <= rdata0;
        rd_data1 <= rdata1;
        rd_busy0 <= busy_src[rd_addr0];
        rd_busy1 <= busy_src[rd_addr1];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a forwarding instance and a non-forwarding instance share stimulus.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr0 = '0, rd_addr1 = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;

  logic [31:0] d0_a, d1_a, d0_b, d1_b, bv_a, bv_b;
  logic        b0_a, b1_a, v_a, b0_b, b1_b, v_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(d0_a), .rd_data1(d1_a), .rd_busy0(b0_a), .rd_busy1(b1_a), .rd_valid(v_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(bv_a)
  );

  regfile_sb #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(d0_b), .rd_data1(d1_b), .rd_busy0(b0_b), .rd_busy1(b1_b), .rd_valid(v_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(bv_b)
  );

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rd_en;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic        e_b0;
    logic        e_b1;
    logic        e_v;
    logic [31:0] e_busy;
    logic [31:0] e_nb_d0;
    logic        e_nb_b0;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    rd_addr0 = '0; rd_addr1 = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
  endtask

  initial begin
    //          wr  waddr wdata         rsv raddr rd  a0  a1  e_d0          e_d1          b0 b1 v  busy          nb_d0         nb_b0
    vecs[0]  = '{0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd5,  5'd9,  32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        0};
    vecs[1]  = '{1, 5'd8,  32'hDEADBEEF, 0, 5'd0,  0, 5'd0,  5'd0,  32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h0,        0};
    vecs[2]  = '{0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 32'h0,        32'hDEADBEEF, 0};
    vecs[3]  = '{1, 5'd3,  32'h12345678, 0, 5'd0,  1, 5'd3,  5'd8,  32'h12345678, 32'hDEADBEEF, 0, 0, 1, 32'h0,        32'h0,        0};
    vecs[4]  = '{1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  1, 5'd0,  5'd3,  32'h0,        32'h12345678, 0, 0, 1, 32'h0,        32'h0,        0};
    vecs[5]  = '{0, 5'd0,  32'h0,        1, 5'd10, 1, 5'd10, 5'd0,  32'h0,        32'h0,        0, 0, 1, 32'h400,      32'h0,        0};
    vecs[6]  = '{0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd10, 5'd10, 32'h0,        32'h0,        1, 1, 1, 32'h400,      32'h0,        1};
    vecs[7]  = '{1, 5'd10, 32'h7,        1, 5'd10, 1, 5'd10, 5'd8,  32'h7,        32'hDEADBEEF, 0, 0, 1, 32'h400,      32'h0,        1};
    vecs[8]  = '{0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd10, 5'd0,  32'h7,        32'h0,        1, 0, 1, 32'h400,      32'h7,        1};
    vecs[9]  = '{1, 5'd10, 32'h9,        0, 5'd0,  1, 5'd10, 5'd0,  32'h9,        32'h0,        0, 0, 1, 32'h0,        32'h7,        1};
    vecs[10] = '{1, 5'd4,  32'hA5,       0, 5'd0,  1, 5'd4,  5'd10, 32'hA5,       32'h9,        0, 0, 1, 32'h0,        32'h0,        0};
    vecs[11] = '{1, 5'd8,  32'h1,        0, 5'd0,  0, 5'd8,  5'd8,  32'hA5,       32'h9,        0, 0, 0, 32'h0,        32'h0,        0};
    vecs[12] = '{1, 5'd6,  32'h66,       0, 5'd0,  1, 5'd6,  5'd6,  32'h66,       32'h66,       0, 0, 1, 32'h0,        32'h0,        0};
    vecs[13] = '{0, 5'd0,  32'h0,        0, 5'd0,  1, 5'd8,  5'd6,  32'h1,        32'h66,       0, 0, 1, 32'h0,        32'h1,        0};

    // Reset state, checked while rst_n is still low.
    repeat (2) @(negedge clk);
    chk("rst_d0", d0_a, 32'h0);
    chk("rst_d1", d1_a, 32'h0);
    chk("rst_valid", {31'h0, v_a}, 32'h0);
    chk("rst_busy0", {31'h0, b0_a}, 32'h0);
    chk("rst_busy_vec", bv_a, 32'h0);
    chk("rst_busy_vec_nb", bv_b, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wr_en = vecs[i].wr_en;   wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr;
      rd_en = vecs[i].rd_en;   rd_addr0 = vecs[i].ra0;    rd_addr1 = vecs[i].ra1;
      @(negedge clk);
      idle_inputs();
      chk($sformatf("v%0d_d0", i), d0_a, vecs[i].e_d0);
      chk($sformatf("v%0d_d1", i), d1_a, vecs[i].e_d1);
      chk($sformatf("v%0d_busy0", i), {31'h0, b0_a}, {31'h0, vecs[i].e_b0});
      chk($sformatf("v%0d_busy1", i), {31'h0, b1_a}, {31'h0, vecs[i].e_b1});
      chk($sformatf("v%0d_valid", i), {31'h0, v_a}, {31'h0, vecs[i].e_v});
      chk($sformatf("v%0d_busy_vec", i), bv_a, vecs[i].e_busy);
      chk($sformatf("v%0d_nb_d0", i), d0_b, vecs[i].e_nb_d0);
      chk($sformatf("v%0d_nb_busy0", i), {31'h0, b0_b}, {31'h0, vecs[i].e_nb_b0});
      chk($sformatf("v%0d_nb_busy_vec", i), bv_b, vecs[i].e_busy);
    end

    // Reserve r12 and read r4 so there is live state for reset to clear.
    rsv_en = 1'b1; rsv_addr = 5'd12; rd_en = 1'b1; rd_addr0 = 5'd4; rd_addr1 = 5'd12;
    @(negedge clk);
    idle_inputs();
    chk("pre_rst_d0", d0_a, 32'hA5);
    chk("pre_rst_busy_vec", bv_a, 32'h1000);

    // Reset asserted between edges clears everything without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy_vec", bv_a, 32'h0);
    chk("async_rst_d0", d0_a, 32'h0);
    chk("async_rst_valid", {31'h0, v_a}, 32'h0);
    // Activity presented across a clock edge while reset is held must be ignored.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77;
    rsv_en = 1'b1; rsv_addr = 5'd5; rd_en = 1'b1; rd_addr0 = 5'd4;
    @(negedge clk);
    idle_inputs();
    chk("in_rst_busy_vec", bv_a, 32'h0);
    chk("in_rst_valid", {31'h0, v_a}, 32'h0);
    rst_n = 1'b1;
    rd_en = 1'b1; rd_addr0 = 5'd4; rd_addr1 = 5'd5;
    @(negedge clk);
    idle_inputs();
    chk("post_rst_d0", d0_a, 32'h0);
    chk("post_rst_nb_d0", d0_b, 32'h0);
    chk("post_rst_busy1", {31'h0, b1_a}, 32'h0);
    chk("post_rst_valid", {31'h0, v_a}, 32'h1);
    chk("post_rst_busy_vec", bv_a, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
